sangdan_monitor: RTL and testbench

- Receive-side checker for the 8-bit fill/drain LED bar pattern, i.e. the sweep 00→01→03→…→FF→7F→…→01→00→01.
- Samples the pattern bus on a strobe and decodes the thermometer code to a level from 0 to 8.
- Locks onto the sweep direction, then flags illegal codes and out-of-sequence steps, and counts completed sweep periods.
- Sits beside the LED driver in self-test builds, or on an input header when monitoring an external bar.

---
 rtl/sangdan_monitor.sv | 67 ++++++
 tb/tb_sangdan_monitor.sv | 123 ++++++++++++
 2 files changed

// File: rtl/sangdan_monitor.sv
// sangdan_monitor: checks a sampled fill/drain LED bar sweep, flags bad codes/steps, counts periods
module sangdan_monitor #(
   parameter int CNT_W      = 16,
   parameter bit ALLOW_HOLD = 1'b0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [7:0]       PAT,
   input  logic             PAT_VALID,
   output logic [3:0]       LEVEL,
   output logic             DIR,
   output logic             LOCKED,
   output logic             ERR,
   output logic             CODE_ERR,
   output logic [7:0]       ERR_CNT,
   output logic [CNT_W-1:0] CYCLE_CNT
);
   localparam logic [1:0] HUNT = 2'd0, ACQ = 2'd1, FILL = 2'd2, DRAIN = 2'd3;
   logic [1:0] state, state_nx;
   logic [3:0] lvl, exp_l, level_nx;
   logic legal, up, dn, match, turn, hold_ok, err_nx, code_err_nx, dir_nx, cyc_inc;
   // LEVEL always holds the previous legal level, so it doubles as the tracked P
   assign legal   = (PAT & (PAT + 8'd1)) == 8'd0;
   assign lvl     = 4'($countones(PAT));
   assign up      = lvl == LEVEL + 4'd1;
   assign dn      = LEVEL != 4'd0 && lvl == LEVEL - 4'd1;
   assign turn    = state == FILL ? LEVEL == 4'd8 : LEVEL == 4'd0;
   assign exp_l   = state == FILL ? (turn ? 4'd7 : LEVEL + 4'd1) : (turn ? 4'd1 : LEVEL - 4'd1);
   assign match   = lvl == exp_l;
   assign hold_ok = ALLOW_HOLD && lvl == LEVEL;
   assign LOCKED  = state == FILL || state == DRAIN;
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= HUNT;
         LEVEL     <= 4'd0;
         DIR       <= 1'b1;
         ERR       <= 1'b0;
         CODE_ERR  <= 1'b0;
         ERR_CNT   <= 8'd0;
         CYCLE_CNT <= '0;
      end else begin
         state     <= state_nx;
         LEVEL     <= level_nx;
         DIR       <= dir_nx;
         ERR       <= err_nx;
         CODE_ERR  <= code_err_nx;
         ERR_CNT   <= ERR_CNT + 8'(err_nx && ERR_CNT != 8'hFF);
         CYCLE_CNT <= CYCLE_CNT + CNT_W'(cyc_inc);
      end
   end
   always_comb begin
      state_nx = state;
      if (PAT_VALID)
         state_nx = !legal ? HUNT :
                    state == HUNT ? ACQ :
                    state == ACQ ? (up ? FILL : dn ? DRAIN : ACQ) :
                    match ? (turn ? (state == FILL ? DRAIN : FILL) : state) :
                    hold_ok ? state : ACQ;
   end
   always_comb begin
      code_err_nx = PAT_VALID && !legal;
      err_nx      = code_err_nx || (PAT_VALID && LOCKED && !match && !hold_ok);
      level_nx    = PAT_VALID && legal ? lvl : LEVEL;
      dir_nx      = state_nx == FILL ? 1'b1 : state_nx == DRAIN ? 1'b0 : DIR;
      cyc_inc     = PAT_VALID && legal && state == DRAIN && turn && match;
   end
endmodule

// File: tb/tb_sangdan_monitor.sv
// tb_sangdan_monitor: table-driven scoreboard bench for the LED bar sweep monitor
module tb_sangdan_monitor;
   typedef struct {
      string      nm;
      logic       rst, vld;
      logic [7:0] pat;
      logic [3:0] lv;
      logic       dir, lk, er, ce;
      logic [7:0] ec;
      logic [15:0] cc;
   } vec_t;
   logic CLK = 1'b0, RST = 1'b1, PAT_VALID = 1'b0;
   logic [7:0] PAT = 8'd0;
   logic [3:0] LEVEL, level_h;
   logic DIR, LOCKED, ERR, CODE_ERR, dir_h, lk_h, err_h, cerr_h;
   logic [7:0] ERR_CNT, ecnt_h;
   logic [15:0] CYCLE_CNT;
   logic [3:0] cyc_h;
   int ncmp = 0, nbad = 0;
   vec_t tbl[$], sb[$];
   always #5 CLK = ~CLK;
   sangdan_monitor dut (
      .CLK(CLK), .RST(RST), .PAT(PAT), .PAT_VALID(PAT_VALID), .LEVEL(LEVEL), .DIR(DIR),
      .LOCKED(LOCKED), .ERR(ERR), .CODE_ERR(CODE_ERR), .ERR_CNT(ERR_CNT), .CYCLE_CNT(CYCLE_CNT)
   );
   sangdan_monitor #(.CNT_W(4), .ALLOW_HOLD(1'b1)) dut_h (
      .CLK(CLK), .RST(RST), .PAT(PAT), .PAT_VALID(PAT_VALID), .LEVEL(level_h), .DIR(dir_h),
      .LOCKED(lk_h), .ERR(err_h), .CODE_ERR(cerr_h), .ERR_CNT(ecnt_h), .CYCLE_CNT(cyc_h)
   );
   function automatic logic [7:0] th(int l);
      return 8'((9'd1 << l) - 9'd1);
   endfunction
   function automatic vec_t mk(string nm, int r, v, p, lv, d, lk, er, ce, ec, cc);
      vec_t x;
      x.nm = nm; x.rst = 1'(r); x.vld = 1'(v); x.pat = 8'(p); x.lv = 4'(lv); x.dir = 1'(d);
      x.lk = 1'(lk); x.er = 1'(er); x.ce = 1'(ce); x.ec = 8'(ec); x.cc = 16'(cc);
      return x;
   endfunction
   task automatic run(input vec_t v);
      vec_t e;
      @(negedge CLK);
      RST = v.rst; PAT_VALID = v.vld; PAT = v.pat;
      sb.push_back(v);
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      ncmp++;
      if ({LEVEL, DIR, LOCKED, ERR, CODE_ERR, ERR_CNT, CYCLE_CNT} !==
          {e.lv, e.dir, e.lk, e.er, e.ce, e.ec, e.cc}) begin
         nbad++;
         $display("FAIL %s pat=%h: got lv=%0d dir=%b lk=%b err=%b cerr=%b ecnt=%0d ccnt=%0d, need lv=%0d dir=%b lk=%b err=%b cerr=%b ecnt=%0d ccnt=%0d",
                  e.nm, e.pat, LEVEL, DIR, LOCKED, ERR, CODE_ERR, ERR_CNT, CYCLE_CNT,
                  e.lv, e.dir, e.lk, e.er, e.ce, e.ec, e.cc);
      end
   endtask
   task automatic chk(input string nm, input int act, input int exp);
      ncmp++;
      if (act != exp) begin
         nbad++;
         $display("FAIL %s: got %0d, need %0d", nm, act, exp);
      end
   endtask
   initial begin
      int sl[$];
      int d, c;
      for (int i = 0; i < 2; i++) tbl.push_back(mk("reset", 1, 1, $urandom_range(255), 0, 1, 0, 0, 0, 0, 0));
      for (int l = 0; l <= 8; l++) sl.push_back(l);
      for (int l = 7; l >= 0; l--) sl.push_back(l);
      for (int l = 1; l <= 8; l++) sl.push_back(l);
      for (int l = 7; l >= 0; l--) sl.push_back(l);
      sl.push_back(1);
      d = 1; c = 0;
      foreach (sl[i]) begin
         if (i > 0 && sl[i] < sl[i-1]) d = 0;
         if (i > 0 && sl[i] > sl[i-1]) d = 1;
         if (i > 1 && sl[i-1] == 0 && sl[i] == 1) c++;
         tbl.push_back(mk("sweep", 0, 1, th(sl[i]), sl[i], d, i > 0, 0, 0, 0, c));
      end
      tbl.push_back(mk("rst_mid", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      for (int l = 0; l <= 3; l++) tbl.push_back(mk("fill", 0, 1, th(l), l, 1, l > 0, 0, 0, 0, 0));
      tbl.push_back(mk("code_err", 0, 1, 8'h05, 3, 1, 0, 1, 1, 1, 0));
      tbl.push_back(mk("idle", 0, 0, 8'hAA, 3, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk("reacq", 0, 1, 8'h0F, 4, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk("relock", 0, 1, 8'h1F, 5, 1, 1, 0, 0, 1, 0));
      tbl.push_back(mk("relock2", 0, 1, 8'h3F, 6, 1, 1, 0, 0, 1, 0));
      tbl.push_back(mk("rst2", 1, 1, 8'h0F, 0, 1, 0, 0, 0, 0, 0));
      for (int l = 0; l <= 4; l++) tbl.push_back(mk("fill4", 0, 1, th(l), l, 1, l > 0, 0, 0, 0, 0));
      tbl.push_back(mk("step_back", 0, 1, 8'h07, 3, 1, 0, 1, 0, 1, 0));
      tbl.push_back(mk("lock_drain", 0, 1, 8'h03, 2, 0, 1, 0, 0, 1, 0));
      tbl.push_back(mk("rst3", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      for (int l = 0; l <= 2; l++) tbl.push_back(mk("pre_sat", 0, 1, th(l), l, 1, l > 0, 0, 0, 0, 0));
      for (int k = 1; k <= 300; k++) tbl.push_back(mk("sat", 0, 1, 8'hAA, 2, 1, 0, 1, 1, k > 255 ? 255 : k, 0));
      tbl.push_back(mk("post_sat0", 0, 1, 8'h00, 0, 1, 0, 0, 0, 255, 0));
      tbl.push_back(mk("post_sat1", 0, 1, 8'h01, 1, 1, 1, 0, 0, 255, 0));
      tbl.push_back(mk("post_sat2", 0, 1, 8'h03, 2, 1, 1, 0, 0, 255, 0));
      tbl.push_back(mk("rst_sat", 1, 1, 8'h07, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk("hunt0", 0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk("lock1", 0, 1, 8'h01, 1, 1, 1, 0, 0, 0, 0));
      for (int i = 0; i < tbl.size(); i++) run(tbl[i]);
      // repeated level: strict instance errors, hold-tolerant instance stays locked
      run(mk("rst_hold", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      for (int l = 0; l <= 5; l++) run(mk("hold_pre", 0, 1, th(l), l, 1, l > 0, 0, 0, 0, 0));
      run(mk("hold_strict", 0, 1, 8'h1F, 5, 1, 0, 1, 0, 1, 0));
      chk("hold_ok_err", int'(err_h), 0);
      chk("hold_ok_lock", int'(lk_h), 1);
      chk("hold_ok_ecnt", int'(ecnt_h), 0);
      run(mk("hold_next", 0, 1, 8'h3F, 6, 1, 1, 0, 0, 1, 0));
      chk("hold_ok_next_lock", int'(lk_h), 1);
      // 16 periods: wide counter reaches 16, 4-bit counter wraps to 0
      run(mk("rst_wrap", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      run(mk("wrap0", 0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0));
      run(mk("wrap1", 0, 1, 8'h01, 1, 1, 1, 0, 0, 0, 0));
      for (int p = 1; p <= 16; p++) begin
         for (int l = 2; l <= 8; l++) run(mk("wrap_up", 0, 1, th(l), l, 1, 1, 0, 0, 0, p - 1));
         for (int l = 7; l >= 0; l--) run(mk("wrap_dn", 0, 1, th(l), l, 0, 1, 0, 0, 0, p - 1));
         run(mk("wrap_turn", 0, 1, 8'h01, 1, 1, 1, 0, 0, 0, p));
         if (p == 15) chk("cyc_narrow_15", int'(cyc_h), 15);
         if (p == 16) chk("cyc_narrow_wrap", int'(cyc_h), 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end
endmodule
